// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, port indices and strobe-counter sizing
// for the two-port memory arbiter (mem_arbiter / arb_rr_sel).
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Port indices: instruction fetch and load/store
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Strobe counter width; MEM_LAT is limited to 1..15
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

  // Strobe cycles remaining after the ISSUE cycle
  function automatic logic [CNT_W-1:0] latInit(input int lat);
    int t;
    t = lat - 1;
    return t[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// arb_rr_sel: turns the last-granted pointer and the two requests into a
// one-hot grant (bit 0 = port 0, bit 1 = port 1).
// Build option: MEM_ARB_FIXED_PRIO_EN -> port 1 always wins a tie and the
// pointer input is removed.
module arb_rr_sel
  import mem_arb_pkg::*;
(
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic       lastGrant,
`endif
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant
);

  // Select the winner; on a tie the port not granted last wins
  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant = 2'b10;
`else
      grant = (lastGrant == PORT_LS) ? 2'b01 : 2'b10;
`endif
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / load-store) arbiter in front of a single
// memory with MEM_LAT strobe cycles per access. FSM IDLE->ISSUE->WAIT->DONE.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 1 wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]       state_r;
  logic [1:0]       nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic             port_r;
  logic             we_r;
  logic [1:0]       grant_s;
  logic             selPort_s;
  logic             selWe_s;
  logic [AW-1:0]    selAddr_s;
  logic [DW-1:0]    selWdata_s;
  logic             nextWe_s;
  logic             strobeNext_s;
  logic             lastStrobe_s;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic             lastGrant_r;
`endif

  arb_rr_sel uSel (
`ifndef MEM_ARB_FIXED_PRIO_EN
    .lastGrant (lastGrant_r),
`endif
    .req0      (req0),
    .req1      (req1),
    .grant     (grant_s)
  );

  // Steer the granted port's request fields and derive strobe timing
  always_comb begin
    selPort_s    = grant_s[1];
    selWe_s      = selPort_s ? we1 : we0;
    selAddr_s    = selPort_s ? addr1 : addr0;
    selWdata_s   = selPort_s ? wdata1 : wdata0;
    nextWe_s     = (state_r == ST_IDLE) ? selWe_s : we_r;
    strobeNext_s = (nextState_s == ST_ISSUE) || (nextState_s == ST_WAIT);
    lastStrobe_s = ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) && (cnt_r == CNT_ZERO);
  end

  // Next-state logic: ISSUE plus MEM_LAT-1 WAIT cycles, then one DONE cycle
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s != 2'b00) nextState_s = ST_ISSUE;
        else                  nextState_s = ST_IDLE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (cnt_r == CNT_ZERO) nextState_s = ST_DONE;
        else                   nextState_s = ST_WAIT;
      end
      ST_DONE: nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // State, latched request, strobe counter and last-granted pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      port_r      <= PORT_IF;
      we_r        <= 1'b0;
      mem_address <= {AW{1'b0}};
      mem_wdata   <= {DW{1'b0}};
`ifndef MEM_ARB_FIXED_PRIO_EN
      lastGrant_r <= PORT_LS;
`endif
    end else begin
      state_r <= nextState_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            port_r      <= selPort_s;
            we_r        <= selWe_s;
            mem_address <= selAddr_s;
            mem_wdata   <= selWdata_s;
            cnt_r       <= latInit(MEM_LAT);
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
        end
        ST_DONE: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
          lastGrant_r <= port_r;
`endif
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Registered strobes, acks and per-port read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= {DW{1'b0}};
      rdata1    <= {DW{1'b0}};
    end else begin
      mem_read  <= strobeNext_s && !nextWe_s;
      mem_write <= strobeNext_s && nextWe_s;
      ack0      <= (nextState_s == ST_DONE) && (port_r == PORT_IF);
      ack1      <= (nextState_s == ST_DONE) && (port_r == PORT_LS);
      if (lastStrobe_s && !we_r) begin
        if (port_r == PORT_LS) rdata1 <= mem_rdata;
        else                   rdata0 <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32: address width, bits.
REQ-002 Parameter DW, default 32: data width, bits.
REQ-003 Parameter MEM_LAT, default 1: memory strobe cycles per access, legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 req0/req1  in  1  access request; port 0 is instruction fetch, port 1 is load/store.
REQ-007 we0/we1  in  1  1 = write (sw), 0 = read (lw).
REQ-008 addr0/addr1  in  AW  word address.
REQ-009 wdata0/wdata1  in  DW  write data.
REQ-010 ack0/ack1  out  1  one-cycle completion pulse.
REQ-011 rdata0/rdata1  out  DW  read data; valid while the matching ack is high, held until that port's next read completes.
REQ-012 mem_address  out  AW  memory address.
REQ-013 mem_read/mem_write  out  1  memory strobes.
REQ-014 mem_wdata  out  DW  memory write data.
REQ-015 mem_rdata  in  DW  memory read data.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE, a rising edge with any req high SHALL latch port, we, addr and wdata into registers and SHALL go to ISSUE.
REQ-018 Arbitration SHALL be round-robin on simultaneous requests: the port not granted last wins; a lone request always wins.
REQ-019 ISSUE SHALL last 1 cycle and WAIT SHALL last MEM_LAT-1 cycles, after which the FSM SHALL enter DONE; with MEM_LAT=1, WAIT SHALL be skipped.
REQ-020 During ISSUE and WAIT, mem_address and mem_wdata SHALL show the latched values, and mem_read=!we or mem_write=we SHALL be asserted.
REQ-021 mem_read and mem_write SHALL never both be high, and SHALL both be low in IDLE and DONE.
REQ-022 On a read, mem_rdata SHALL be captured on the edge leaving the last strobe cycle into the granted port's rdata register.
REQ-023 In DONE, the granted port's ack SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE and update the last-granted pointer.
REQ-024 A requester SHALL hold req, we, addr and wdata stable until its ack; req sampled in IDLE after DONE SHALL be treated as a new request.
REQ-025 Requests arriving while the FSM is not in IDLE SHALL wait without loss; the ungranted port SHALL never see ack.
REQ-026 Latency from grant edge to ack SHALL be MEM_LAT+1 cycles; peak throughput SHALL be one access per MEM_LAT+2 cycles.

Reset
REQ-027 With rst_n low at an edge: state=IDLE, both acks=0, both strobes=0, mem_address=0, mem_wdata=0, rdata0=rdata1=0, and the last-granted pointer=1, so port 0 wins the first tie.
REQ-028 Reset mid-transaction SHALL abort the access with no ack issued; the requester re-requests after reset.

Configuration
REQ-029 When the macro MEM_ARB_FIXED_PRIO_EN is defined, port 1 SHALL always win simultaneous requests and the pointer SHALL be unused.
REQ-030 When MEM_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-018.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the FSM state encoding, the port index constants PORT_IF=0 and PORT_LS=1, and the MEM_LAT counter width.
REQ-032 The grant selection (pointer plus requests to one-hot grant) SHALL be a sub-module, arb_rr_sel.

Verification
REQ-033 MEM_LAT=1; req0 read addr=5 with mem[5]=0x0000_00AA -> mem_read high 1 cycle with mem_address=5; ack0 2 cycles after grant edge; rdata0=0xAA.
REQ-034 req1 write addr=7, wdata=0x1234_5678 -> mem_write high MEM_LAT cycles with mem_address=7 and mem_wdata=0x12345678; ack1 pulses once; ack0 never.
REQ-035 req0 and req1 held high continuously -> grants alternate 0,1,0,1 starting with port 0; acks never overlap; read-back data is correct per port.
REQ-036 MEM_LAT=3; single read -> strobe high exactly 3 cycles; ack 4 cycles after grant edge.
REQ-037 rst_n low during WAIT -> next cycle is IDLE with strobes 0; no ack; a fresh request then completes normally.
REQ-038 With MEM_ARB_FIXED_PRIO_EN defined, both ports held high -> port 1 granted every time; port 0 starves until req1 drops.
